mips_pipe_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_dmem_wait_fsm.sv | 78 +++++++
 rtl/mips_pipe_ctrl.sv | 96 +++++++++
 tb/tb_mips_pipe_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared core types: opcodes and pipeline-control state encoding.
package mips_pkg;

  typedef enum logic [3:0] {
    NEM_NOP,
    NEM_ADD,
    NEM_SUB,
    NEM_LW,
    NEM_SW,
    NEM_BEQ,
    NEM_J
  } t_instr_pnmen;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } t_pipe_ctrl_state;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 16;

  function automatic logic is_mem_op(t_instr_pnmen op);
    return (op == NEM_LW) || (op == NEM_SW);
  endfunction

endpackage

// File: rtl/mips_dmem_wait_fsm.sv
// Data-memory wait tracker: owns the bus wait state, the wait counter, the
// global stall and the sticky timeout error.
module mips_dmem_wait_fsm
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req_m,
  input  logic             dmem_ack_m,
  output logic             stall_all,
  output logic             dmem_err,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

  t_pipe_ctrl_state state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: wait for the ack, give up after MEM_TIMEOUT wait cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req_m && !dmem_ack_m) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_m) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: ;
      default: state_d = ERR;
    endcase
  end

  // Outputs: an ack releases the stall in the cycle it arrives; ERR freezes all.
  always_comb begin
    stall_all = 1'b0;
    dmem_err  = 1'b0;
    case (state_q)
      RUN:      stall_all = mem_req_m & ~dmem_ack_m;
      MEM_WAIT: stall_all = ~dmem_ack_m;
      default: begin
        stall_all = 1'b1;
        dmem_err  = 1'b1;
      end
    endcase
  end

  assign wait_cnt = cnt_q;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Central pipeline control: stage valid bits, stall/flush generation and the
// forwarding write-enable qualifiers.
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid_f,
  input  logic             branch_taken_e,
  input  t_instr_pnmen     intr_opcode_m,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             dmem_ack_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             valid_d,
  output logic             valid_e,
  output logic             valid_m,
  output logic             valid_w,
  output logic             reg_write_hzd_free_m,
  output logic             reg_write_hzd_free_w,
  output logic             reg_write_hzd_free_w_plus1,
  output logic             dmem_err,
  output logic [CNT_W-1:0] wait_cnt
);

  logic mem_req_m;
  logic stall_all;
  logic flush;
  logic valid_w_plus1;
  logic reg_write_w_plus1;

  assign mem_req_m = valid_m & is_mem_op(intr_opcode_m);

  mips_dmem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_req_m (mem_req_m),
    .dmem_ack_m(dmem_ack_m),
    .stall_all (stall_all),
    .dmem_err  (dmem_err),
    .wait_cnt  (wait_cnt)
  );

  // A stalled E re-presents the branch, so the flush lands in the release cycle.
  assign flush   = branch_taken_e & valid_e & ~stall_all;
  assign flush_d = flush;
  assign flush_e = flush;
  assign stall_f = stall_all;
  assign stall_d = stall_all;
  assign stall_e = stall_all;
  assign stall_m = stall_all;

  // Valid chain: on stall F..M hold and a bubble drains into W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d <= 1'b0;
      valid_e <= 1'b0;
      valid_m <= 1'b0;
      valid_w <= 1'b0;
    end else if (stall_all) begin
      valid_w <= 1'b0;
    end else begin
      valid_d <= fetch_valid_f & ~flush;
      valid_e <= valid_d & ~flush;
      valid_m <= valid_e;
      valid_w <= valid_m;
    end
  end

  // W+1 history for the oldest forwarding source; never stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_w_plus1     <= 1'b0;
      reg_write_w_plus1 <= 1'b0;
    end else begin
      valid_w_plus1     <= valid_w;
      reg_write_w_plus1 <= reg_write_w;
    end
  end

  assign reg_write_hzd_free_m       = reg_write_m & valid_m;
  assign reg_write_hzd_free_w       = reg_write_w & valid_w;
  assign reg_write_hzd_free_w_plus1 = reg_write_w_plus1 & valid_w_plus1;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Bench for mips_pipe_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_mips_pipe_ctrl;
  import mips_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_valid_f, branch_taken_e, reg_write_m, reg_write_w, dmem_ack_m;
  t_instr_pnmen  op;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic          valid_d, valid_e, valid_m, valid_w;
  logic          hzd_m, hzd_w, hzd_wp1, dmem_err;
  logic [CW-1:0] wait_cnt;

  mips_pipe_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .fetch_valid_f             (fetch_valid_f),
    .branch_taken_e            (branch_taken_e),
    .intr_opcode_m             (op),
    .reg_write_m               (reg_write_m),
    .reg_write_w               (reg_write_w),
    .dmem_ack_m                (dmem_ack_m),
    .stall_f                   (stall_f),
    .stall_d                   (stall_d),
    .stall_e                   (stall_e),
    .stall_m                   (stall_m),
    .flush_d                   (flush_d),
    .flush_e                   (flush_e),
    .valid_d                   (valid_d),
    .valid_e                   (valid_e),
    .valid_m                   (valid_m),
    .valid_w                   (valid_w),
    .reg_write_hzd_free_m      (hzd_m),
    .reg_write_hzd_free_w      (hzd_w),
    .reg_write_hzd_free_w_plus1(hzd_wp1),
    .dmem_err                  (dmem_err),
    .wait_cnt                  (wait_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stage occupancy array (0=D,1=E,2=M,3=W), cycles spent
  // waiting on the bus so far, and a sticky dead-bus flag.
  bit mv[4];
  bit m_wp1, m_rwp1, m_err;
  int m_waited;

  function automatic bit m_req();
    return mv[2] && (op == NEM_LW || op == NEM_SW);
  endfunction

  function automatic bit m_stall();
    return m_err || (!dmem_ack_m && (m_waited > 0 || m_req()));
  endfunction

  function automatic bit m_flush();
    return branch_taken_e && mv[1] && !m_stall();
  endfunction

  always @(posedge clk or negedge rst) begin
    bit st, fl, rq;
    if (!rst) begin
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      m_wp1 = 1'b0; m_rwp1 = 1'b0; m_err = 1'b0; m_waited = 0;
    end else begin
      st = m_stall(); fl = m_flush(); rq = m_req();
      m_wp1  = mv[3];
      m_rwp1 = reg_write_w;
      if (st) begin
        mv[3] = 1'b0;
      end else begin
        mv[3] = mv[2];
        mv[2] = mv[1];
        mv[1] = mv[0] && !fl;
        mv[0] = fetch_valid_f && !fl;
      end
      if (!m_err) begin
        if (m_waited == 0) begin
          if (rq && !dmem_ack_m) m_waited = 1;
        end else if (dmem_ack_m) begin
          m_waited = 0;
        end else if (m_waited == int'(TO)) begin
          m_err = 1'b1;
        end else begin
          m_waited++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit st, fl;
    st = m_stall();
    fl = m_flush();
    chk("stall_f", stall_f, st);
    chk("stall_d", stall_d, st);
    chk("stall_e", stall_e, st);
    chk("stall_m", stall_m, st);
    chk("flush_d", flush_d, fl);
    chk("flush_e", flush_e, fl);
    chk("valid_d", valid_d, mv[0]);
    chk("valid_e", valid_e, mv[1]);
    chk("valid_m", valid_m, mv[2]);
    chk("valid_w", valid_w, mv[3]);
    chk("hzd_m", hzd_m, reg_write_m && mv[2]);
    chk("hzd_w", hzd_w, reg_write_w && mv[3]);
    chk("hzd_wp1", hzd_wp1, m_rwp1 && m_wp1);
    chk("dmem_err", dmem_err, m_err);
    if (!m_err) chk("wait_cnt", wait_cnt, m_waited);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int stalls;

  initial begin
    fetch_valid_f = 1'b0; branch_taken_e = 1'b0; reg_write_m = 1'b1; reg_write_w = 1'b1;
    op = NEM_LW; dmem_ack_m = 1'b0;
    #3;
    // In reset: M invalid, so the pending LW raises nothing.
    chk("rst_stall", stall_f, 0);
    chk("rst_flush", flush_d, 0);
    chk("rst_valid_w", valid_w, 0);
    chk("rst_hzd_m", hzd_m, 0);
    chk("rst_err", dmem_err, 0);
    cyc();
    rst = 1'b1; fetch_valid_f = 1'b1; op = NEM_NOP;

    // Fill ramp.
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("ramp_valid_e", valid_e, k >= 2);
      chk("ramp_valid_w", valid_w, k >= 4);
    end
    chk("ramp_hzd_w", hzd_w, 1);
    cyc();
    chk("ramp_hzd_wp1", hzd_wp1, 1);

    // LW with three ack-less cycles.
    op = NEM_LW; stalls = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_ack_m = (c == 3);
      #3;
      stalls += int'(stall_f);
      chk("lw_wait_cnt", wait_cnt, c);
      cyc();
    end
    op = NEM_NOP;
    chk("lw_stall_cycles", stalls, 3);
    chk("lw_wait_cnt_after", wait_cnt, 0);
    chk("lw_reaches_w", valid_w, 1);

    // Taken branch, no stall.
    branch_taken_e = 1'b1;
    #3;
    chk("br_flush_d", flush_d, 1);
    chk("br_flush_e", flush_e, 1);
    cyc();
    branch_taken_e = 1'b0;
    chk("br_valid_e", valid_e, 0);
    chk("br_valid_d", valid_d, 0);
    cyc();
    chk("br_bubble_hzd_m", hzd_m, 0);
    repeat (4) cyc();

    // Taken branch during a 2-cycle bus stall.
    op = NEM_LW; branch_taken_e = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dmem_ack_m = (c == 2);
      #3;
      chk("brst_flush", flush_d, c == 2);
      chk("brst_stall", stall_f, c != 2);
      cyc();
    end
    op = NEM_NOP; branch_taken_e = 1'b0;
    chk("brst_bubble_e", valid_e, 0);
    repeat (4) cyc();

    // Never-acked access: timeout into ERR.
    op = NEM_LW; dmem_ack_m = 1'b0; stalls = 0;
    for (int c = 0; c < 7; c++) begin
      #3;
      if (c < 5) stalls += int'(stall_f);
      chk("to_err", dmem_err, c >= 5);
      cyc();
    end
    chk("to_stall_cycles", stalls, 5);
    dmem_ack_m = 1'b1;
    repeat (2) begin
      #3;
      chk("to_late_ack_err", dmem_err, 1);
      chk("to_late_ack_stall", stall_f, 1);
      cyc();
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_err", dmem_err, 0);
    chk("arst_valid_m", valid_m, 0);
    chk("arst_stall", stall_f, 0);
    chk("arst_wait_cnt", wait_cnt, 0);
    #3 rst = 1'b1;
    fetch_valid_f = 1'b0; reg_write_w = 1'b1;
    cyc();
    chk("bubble_hzd_wp1", hzd_wp1, 0);

    // Randomized traffic with periodic bus starvation and resets.
    for (int i = 0; i < 3000; i++) begin
      fetch_valid_f  = ($urandom_range(0, 3) != 0);
      branch_taken_e = ($urandom_range(0, 4) == 0);
      op             = t_instr_pnmen'(4'($urandom_range(0, 6)));
      reg_write_m    = 1'($urandom_range(0, 1));
      reg_write_w    = 1'($urandom_range(0, 1));
      dmem_ack_m     = ((i % 400) >= 380) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if ((i % 400) == 399 || $urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
